enemy_swarm_ctrl: RTL and testbench
===================================

# enemy_swarm_ctrl

Parametrised formation controller for the invader swarm: it generalises the fixed-grid enemy block to configurable rows, columns, explosion slots and march speed-up. It keeps the alive bitmap and marches the formation right, down and left. It resolves projectile hits into grid cells with score, runs several concurrent explosion timers and issues enemy-fire requests through a handshake. It sits between the collision unit and the enemy/explosion renderers, in the LCD pixel-clock domain.

## Interface
- NB_ROWS, 5, formation rows (1..8)
- NB_COLS, 10, formation columns (1..16)
- ENEMY_W, 46 / ENEMY_H, 42: cell pitch in pixels
- X0, 100 / Y0, 45: formation origin after reset
- X_MAX, 655 / Y_MAX, 490: right border and "invasion" line
- STEP, 15 / ADVANCE, 15: horizontal step and descend distance in pixels
- BASE_PERIOD, 32 / MIN_PERIOD, 2: frames per march step, initial and floor
- SPEEDUP_SHIFT, 1: period shrinks by kills >> SPEEDUP_SHIFT
- N_EXPL, 4: concurrent explosion slots
- EXPL_FRAMES, 20: explosion lifetime in frames
- FIRE_PERIOD, 48: frames between fire attempts
- clk in 1 pixel clock
- rst_n in 1 synchronous, active-low reset
- lcd_xpos, lcd_ypos in 12 each: raster position; frame tick = both zero
- enable in 1: game running
- freeze in 1: pause
- killed_enemy_x, killed_enemy_y in 12 each: hit point
- valid_enemy_collision in 1: hit point valid this cycle
- fire_ack in 1: bullet unit accepted the fire request
- form_x, form_y out 12 each: formation top-left corner
- alive out NB_ROWS*NB_COLS: bit r*NB_COLS+c = enemy (r,c) alive
- kill_busy out 1: hit resolution in progress
- plus_score out 2: one-cycle score pulse, 0 otherwise
- finished out 3: 0 playing, 1 swarm cleared, 2 invasion
- expl_valid out N_EXPL: slot active
- expl_x, expl_y out 12*N_EXPL each: slot cell corner
- fire_req out 1 / fire_x, fire_y out 12 each: shot origin (cell bottom-centre)

## Operation
- Reset values:
  - form_x=X0, form_y=Y0
  - alive all ones
  - kill_busy=0, plus_score=0, finished=0
  - expl_valid=0, fire_req=0
  - LFSR=16'hACE1
  - march FSM in MARCH_R
  - frame counters cleared
- March FSM: MARCH_R, MARCH_L, DESCEND, DONE.
  - It advances only on a frame tick with enable=1, freeze=0 and frame count = period-1. The count then clears.
  - period = max(MIN_PERIOD, BASE_PERIOD - (kills >> SPEEDUP_SHIFT)).
  - Bounds use the leftmost and rightmost alive columns, not the full grid.
  - MARCH_R: if right edge + STEP > X_MAX, go to DESCEND and return to MARCH_L; otherwise form_x += STEP.
  - MARCH_L: if left edge < STEP, go to DESCEND and return to MARCH_R; otherwise form_x -= STEP.
  - DESCEND: form_y += ADVANCE, once. If the bottom of the lowest alive row reaches or exceeds Y_MAX, set finished=2 and enter DONE.
  - alive == 0 → finished=1, DONE.
  - DONE holds until reset.
- Hit resolution FSM: IDLE, COL, ROW, APPLY.
  - In IDLE, valid_enemy_collision with enable=1 latches dx = x - form_x and dy = y - form_y, and raises kill_busy.
  - A negative dx or dy (MSB set after 13-bit subtract) returns to IDLE with no effect.
  - COL and ROW use repeated subtraction of ENEMY_W / ENEMY_H, one per cycle, to find c and r.
  - An index reaching NB_COLS / NB_ROWS aborts the resolution.
  - APPLY: if alive[r,c] is set, clear it, increment kills (saturating 8-bit) and pulse plus_score: 3 for row 0, 2 for rows 1–2, 1 otherwise. It also allocates an explosion at the cell corner.
  - APPLY on a dead cell does nothing.
  - Collisions arriving while kill_busy=1 are ignored.
  - Kills are processed during freeze.
- Explosions:
  - Allocation takes the lowest free slot.
  - If all slots are busy, it overwrites the round-robin pointer slot and the pointer increments mod N_EXPL.
  - Each slot counts down on frame ticks while freeze=0, and clears at EXPL_FRAMES.
- Fire:
  - The LFSR (x^16+x^14+x^13+x^11) steps every frame tick.
  - The fire column advances by lfsr[2:0] mod NB_COLS, wrapping, each frame.
  - Every FIRE_PERIOD unfrozen frames, the lowest alive row in that column is found by a row scan, one cycle per row.
  - If one exists, fire_req rises with fire_x = form_x + c*ENEMY_W + ENEMY_W/2 and fire_y = form_y + (r+1)*ENEMY_H.
  - An empty column means no request that period.
- enable=0: march, fire and timers hold; outputs keep their values.

## Timing
- form_x/form_y update the cycle after the qualifying frame tick.
- plus_score pulse arrives 3 + c + r cycles after the collision cycle, ±0; the alive bit clears in the same cycle.
- kill_busy falls the cycle after APPLY or an abort.
- fire_req stays high, with fire_x/fire_y stable, until the cycle fire_ack=1 is sampled, then drops the next cycle. No new attempt occurs while it is pending.
- Synchronous reset mid-resolution or mid-request restores all reset values on the next edge.

## Test plan
- Reset, enable=1, BASE_PERIOD=2: after 2 frame ticks form_x=115. At the right border the next step gives form_y=60, then form_x decrements by 15.
- Hit at (X0+50, Y0+90): kill_busy for 6 cycles (3+c+r, c=1, r=2), alive bit 21 clears, plus_score=2 for 1 cycle, expl slot 0 at (146,129).
- Same hit repeated, plus a hit at (X0-5, Y0): no score, alive unchanged.
- Kill all cells of column 9: the formation marches further right, with the right edge computed from column 8.
- Five kills with N_EXPL=4 and all slots live: the fifth overwrites slot 0; all slots clear after 20 frames; freeze stretches their lifetime.
- fire_ack held low for 100 cycles: fire_req stays high with coordinates stable, then drops one cycle after fire_ack. Clearing all enemies gives finished=1.

Source files
------------

// File: rtl/enemy_swarm_ctrl.sv
// Invader swarm formation controller: march, hit resolution,
// explosion slots and enemy fire requests.
module enemy_swarm_ctrl #(
    parameter int NB_ROWS       = 5,
    parameter int NB_COLS       = 10,
    parameter int ENEMY_W       = 46,
    parameter int ENEMY_H       = 42,
    parameter int X0            = 100,
    parameter int Y0            = 45,
    parameter int X_MAX         = 655,
    parameter int Y_MAX         = 490,
    parameter int STEP          = 15,
    parameter int ADVANCE       = 15,
    parameter int BASE_PERIOD   = 32,
    parameter int MIN_PERIOD    = 2,
    parameter int SPEEDUP_SHIFT = 1,
    parameter int N_EXPL        = 4,
    parameter int EXPL_FRAMES   = 20,
    parameter int FIRE_PERIOD   = 48
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [11:0]                  lcd_xpos,
    input  logic [11:0]                  lcd_ypos,
    input  logic                         enable,
    input  logic                         freeze,
    input  logic [11:0]                  killed_enemy_x,
    input  logic [11:0]                  killed_enemy_y,
    input  logic                         valid_enemy_collision,
    input  logic                         fire_ack,
    output logic [11:0]                  form_x,
    output logic [11:0]                  form_y,
    output logic [NB_ROWS*NB_COLS-1:0]   alive,
    output logic                         kill_busy,
    output logic [1:0]                   plus_score,
    output logic [2:0]                   finished,
    output logic [N_EXPL-1:0]            expl_valid,
    output logic [12*N_EXPL-1:0]         expl_x,
    output logic [12*N_EXPL-1:0]         expl_y,
    output logic                         fire_req,
    output logic [11:0]                  fire_x,
    output logic [11:0]                  fire_y
);
    localparam int NC = NB_ROWS * NB_COLS;
    localparam int SW = (N_EXPL > 1) ? $clog2(N_EXPL) : 1;
    localparam logic [12:0] EW = 13'(ENEMY_W);
    localparam logic [12:0] EH = 13'(ENEMY_H);

    typedef enum logic [1:0] {MARCH_R, MARCH_L, DESCEND, DONE} march_t;
    typedef enum logic [1:0] {H_IDLE, H_COL, H_ROW, H_APPLY} hit_t;
    typedef enum logic [1:0] {F_IDLE, F_SCAN, F_REQ} fire_t;

    march_t m_state, m_next;
    hit_t   h_state, h_next;
    fire_t  f_state, f_next;

    logic        tick, run, step;
    logic        ret_l, ret_next;
    logic [15:0] fcnt, fc_next, period, slow;
    logic [11:0] fx_next, fy_next;
    logic [2:0]  fin_next;
    logic [7:0]  kills;
    logic [NB_COLS-1:0] col_any;
    logic [NB_ROWS-1:0] row_any;
    logic [4:0]  col_lo, col_hi;
    logic [3:0]  row_hi;
    logic [12:0] left_edge, right_edge, bottom;
    logic [12:0] dx, dy;
    logic [4:0]  hc, scol, fire_col;
    logic [3:0]  hr, srow;
    logic [NC-1:0] cell_mask, scan_mask;
    logic        hit_live, scan_hit, fire_go, free_any;
    logic [SW-1:0] free_idx, rr, slot;
    logic [7:0]  ecnt [N_EXPL];
    logic [15:0] lfsr, fire_cnt;

    assign tick = (lcd_xpos == 12'd0) && (lcd_ypos == 12'd0) && enable;
    assign run  = tick && !freeze;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < NB_ROWS; r++)
            for (int c = 0; c < NB_COLS; c++)
                if (alive[r*NB_COLS+c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
        col_lo = '0;
        col_hi = '0;
        row_hi = '0;
        for (int c = NB_COLS - 1; c >= 0; c--)
            if (col_any[c]) col_lo = 5'(c);
        for (int c = 0; c < NB_COLS; c++)
            if (col_any[c]) col_hi = 5'(c);
        for (int r = 0; r < NB_ROWS; r++)
            if (row_any[r]) row_hi = 4'(r);
    end

    // Bounds follow the surviving columns and rows only
    assign left_edge  = 13'(form_x) + 13'(col_lo) * EW;
    assign right_edge = 13'(form_x) + (13'(col_hi) + 13'd1) * EW;
    assign bottom     = 13'(form_y) + (13'(row_hi) + 13'd1) * EH;

    assign slow   = 16'(kills >> SPEEDUP_SHIFT);
    assign period = (16'(BASE_PERIOD) >= slow + 16'(MIN_PERIOD)) ?
                    16'(BASE_PERIOD) - slow : 16'(MIN_PERIOD);

    always_comb begin
        m_next   = m_state;
        ret_next = ret_l;
        fx_next  = form_x;
        fy_next  = form_y;
        fin_next = finished;
        fc_next  = fcnt;
        step     = 1'b0;
        if (run) begin
            if (fcnt >= period - 16'd1) begin
                fc_next = '0;
                step    = 1'b1;
            end else begin
                fc_next = fcnt + 16'd1;
            end
        end
        if (m_state != DONE && alive == '0) begin
            m_next   = DONE;
            fin_next = 3'd1;
        end else if (step) begin
            unique case (m_state)
                MARCH_R:
                    if (right_edge + 13'(STEP) > 13'(X_MAX)) begin
                        m_next   = DESCEND;
                        ret_next = 1'b1;
                    end else begin
                        fx_next = form_x + 12'(STEP);
                    end
                MARCH_L:
                    if (left_edge < 13'(STEP)) begin
                        m_next   = DESCEND;
                        ret_next = 1'b0;
                    end else begin
                        fx_next = form_x - 12'(STEP);
                    end
                DESCEND: begin
                    fy_next = form_y + 12'(ADVANCE);
                    m_next  = ret_l ? MARCH_L : MARCH_R;
                    if (bottom + 13'(ADVANCE) >= 13'(Y_MAX)) begin
                        m_next   = DONE;
                        fin_next = 3'd2;
                    end
                end
                DONE: ;
            endcase
        end
    end

    assign cell_mask = NC'(1) << (8'(hr) * 8'(NB_COLS) + 8'(hc));
    assign hit_live  = |(alive & cell_mask);
    assign kill_busy = (h_state != H_IDLE);

    always_comb begin
        h_next = h_state;
        unique case (h_state)
            H_IDLE:
                if (valid_enemy_collision && enable) h_next = H_COL;
            H_COL:
                if (dx[12] || dy[12])
                    h_next = H_IDLE;
                else if (dx >= EW)
                    h_next = (hc + 5'd1 == 5'(NB_COLS)) ? H_IDLE : H_COL;
                else
                    h_next = H_ROW;
            H_ROW:
                if (dy >= EH)
                    h_next = (hr + 4'd1 == 4'(NB_ROWS)) ? H_IDLE : H_ROW;
                else
                    h_next = H_APPLY;
            H_APPLY: h_next = H_IDLE;
        endcase
    end

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = N_EXPL - 1; i >= 0; i--)
            if (!expl_valid[i]) begin
                free_any = 1'b1;
                free_idx = SW'(i);
            end
    end
    assign slot = free_any ? free_idx : rr;

    assign scan_mask = NC'(1) << (8'(srow) * 8'(NB_COLS) + 8'(scol));
    assign scan_hit  = |(alive & scan_mask);
    assign fire_go   = run && (fire_cnt == 16'(FIRE_PERIOD - 1)) &&
                       (f_state == F_IDLE);
    assign fire_req  = (f_state == F_REQ);

    always_comb begin
        f_next = f_state;
        unique case (f_state)
            F_IDLE: if (fire_go) f_next = F_SCAN;
            F_SCAN:
                if (scan_hit) f_next = F_REQ;
                else if (srow == 4'd0) f_next = F_IDLE;
            F_REQ: if (fire_ack) f_next = F_IDLE;
            default: f_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_state  <= MARCH_R;
            h_state  <= H_IDLE;
            f_state  <= F_IDLE;
            ret_l    <= 1'b0;
            fcnt     <= '0;
            form_x   <= 12'(X0);
            form_y   <= 12'(Y0);
            finished <= '0;
        end else begin
            m_state  <= m_next;
            h_state  <= h_next;
            f_state  <= f_next;
            ret_l    <= ret_next;
            fcnt     <= fc_next;
            form_x   <= fx_next;
            form_y   <= fy_next;
            finished <= fin_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alive      <= '1;
            kills      <= '0;
            plus_score <= '0;
            dx         <= '0;
            dy         <= '0;
            hc         <= '0;
            hr         <= '0;
            expl_valid <= '0;
            expl_x     <= '0;
            expl_y     <= '0;
            rr         <= '0;
            for (int i = 0; i < N_EXPL; i++) ecnt[i] <= '0;
            lfsr       <= 16'hACE1;
            fire_cnt   <= '0;
            fire_col   <= '0;
            scol       <= '0;
            srow       <= '0;
            fire_x     <= '0;
            fire_y     <= '0;
        end else begin
            plus_score <= 2'd0;
            if (run)
                for (int i = 0; i < N_EXPL; i++)
                    if (expl_valid[i]) begin
                        if (ecnt[i] == 8'(EXPL_FRAMES - 1))
                            expl_valid[i] <= 1'b0;
                        else
                            ecnt[i] <= ecnt[i] + 8'd1;
                    end
            unique case (h_state)
                H_IDLE:
                    if (valid_enemy_collision && enable) begin
                        dx <= 13'(killed_enemy_x) - 13'(form_x);
                        dy <= 13'(killed_enemy_y) - 13'(form_y);
                        hc <= '0;
                        hr <= '0;
                    end
                H_COL:
                    if (dx >= EW) begin
                        dx <= dx - EW;
                        hc <= hc + 5'd1;
                    end
                H_ROW:
                    if (dy >= EH) begin
                        dy <= dy - EH;
                        hr <= hr + 4'd1;
                    end
                H_APPLY:
                    if (hit_live) begin
                        alive <= alive & ~cell_mask;
                        if (kills != 8'hFF) kills <= kills + 8'd1;
                        plus_score <= (hr == 4'd0) ? 2'd3 :
                                      (hr <= 4'd2) ? 2'd2 : 2'd1;
                        expl_valid[slot] <= 1'b1;
                        ecnt[slot] <= '0;
                        expl_x[12*slot +: 12] <=
                            form_x + 12'(hc) * 12'(ENEMY_W);
                        expl_y[12*slot +: 12] <=
                            form_y + 12'(hr) * 12'(ENEMY_H);
                        if (!free_any)
                            rr <= (rr == SW'(N_EXPL - 1)) ? '0 : rr + 1'b1;
                    end
            endcase
            if (tick) begin
                lfsr <= {lfsr[14:0],
                         lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                fire_col <= 5'((6'(fire_col) + 6'(lfsr[2:0])) %
                               6'(NB_COLS));
            end
            if (run)
                fire_cnt <= (fire_cnt == 16'(FIRE_PERIOD - 1)) ?
                            '0 : fire_cnt + 16'd1;
            if (fire_go) begin
                srow <= 4'(NB_ROWS - 1);
                scol <= fire_col;
            end
            if (f_state == F_SCAN) begin
                if (scan_hit) begin
                    fire_x <= form_x + 12'(scol) * 12'(ENEMY_W) +
                              12'(ENEMY_W / 2);
                    fire_y <= form_y + (12'(srow) + 12'd1) * 12'(ENEMY_H);
                end else if (srow != 4'd0) begin
                    srow <= srow - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_enemy_swarm_ctrl.sv
// Directed testbench for enemy_swarm_ctrl: march, hits, explosions,
// fire handshake and swarm-cleared detection.
module tb_enemy_swarm_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] lcd_xpos, lcd_ypos;
    logic        enable, freeze;
    logic [11:0] killed_enemy_x, killed_enemy_y;
    logic        valid_enemy_collision, fire_ack;
    logic [11:0] form_x, form_y;
    logic [49:0] alive;
    logic        kill_busy;
    logic [1:0]  plus_score;
    logic [2:0]  finished;
    logic [3:0]  expl_valid;
    logic [47:0] expl_x, expl_y;
    logic        fire_req;
    logic [11:0] fire_x, fire_y;

    logic [49:0] exp_alive;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    enemy_swarm_ctrl #(
        .BASE_PERIOD(2),
        .FIRE_PERIOD(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lcd_xpos(lcd_xpos),
        .lcd_ypos(lcd_ypos),
        .enable(enable),
        .freeze(freeze),
        .killed_enemy_x(killed_enemy_x),
        .killed_enemy_y(killed_enemy_y),
        .valid_enemy_collision(valid_enemy_collision),
        .fire_ack(fire_ack),
        .form_x(form_x),
        .form_y(form_y),
        .alive(alive),
        .kill_busy(kill_busy),
        .plus_score(plus_score),
        .finished(finished),
        .expl_valid(expl_valid),
        .expl_x(expl_x),
        .expl_y(expl_y),
        .fire_req(fire_req),
        .fire_x(fire_x),
        .fire_y(fire_y)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        freeze = 1'b0;
        lcd_xpos = 12'd1;
        lcd_ypos = 12'd0;
        valid_enemy_collision = 1'b0;
        killed_enemy_x = '0;
        killed_enemy_y = '0;
        fire_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            lcd_xpos = 12'd0;
            lcd_ypos = 12'd0;
            @(posedge clk);
            #1 lcd_xpos = 12'd1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hit(input int x, input int y);
        killed_enemy_x = 12'(x);
        killed_enemy_y = 12'(y);
        valid_enemy_collision = 1'b1;
        @(posedge clk);
        #1 valid_enemy_collision = 1'b0;
    endtask

    task automatic wait_idle(output int cyc, output logic [1:0] sc);
        cyc = 0;
        sc = 2'd0;
        while (kill_busy && cyc < 50) begin
            @(posedge clk);
            #1 cyc++;
            if (plus_score != 2'd0) sc = plus_score;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (form_x !== 12'd100 || form_y !== 12'd45) begin
            n_fail++;
            $display("FAIL reset_pos: got (%0d,%0d) expected (100,45)", form_x, form_y);
        end
        n_tests++;
        if (alive !== {50{1'b1}}) begin
            n_fail++;
            $display("FAIL reset_alive: got %h expected all ones", alive);
        end
        n_tests++;
        if (kill_busy !== 1'b0 || plus_score !== 2'd0 || finished !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b score=%0d fin=%0d expected 0/0/0", kill_busy, plus_score, finished);
        end
        n_tests++;
        if (expl_valid !== 4'b0 || fire_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_expl_fire: expl=%b fire=%b expected 0/0", expl_valid, fire_req);
        end
    endtask

    task automatic test_march();
        do_reset();
        enable = 1'b0;
        frames(4);
        enable = 1'b1;
        n_tests++;
        if (form_x !== 12'd100) begin
            n_fail++;
            $display("FAIL march_hold_disabled: form_x=%0d expected 100", form_x);
        end
        frames(1);
        n_tests++;
        if (form_x !== 12'd100) begin
            n_fail++;
            $display("FAIL march_tick1: form_x=%0d expected 100", form_x);
        end
        frames(1);
        n_tests++;
        if (form_x !== 12'd115) begin
            n_fail++;
            $display("FAIL march_tick2: form_x=%0d expected 115", form_x);
        end
        frames(10);
        n_tests++;
        if (form_x !== 12'd190) begin
            n_fail++;
            $display("FAIL march_right_limit: form_x=%0d expected 190", form_x);
        end
        frames(2);
        n_tests++;
        if (form_x !== 12'd190 || form_y !== 12'd45) begin
            n_fail++;
            $display("FAIL march_border: got (%0d,%0d) expected (190,45)", form_x, form_y);
        end
        frames(2);
        n_tests++;
        if (form_x !== 12'd190 || form_y !== 12'd60) begin
            n_fail++;
            $display("FAIL march_descend: got (%0d,%0d) expected (190,60)", form_x, form_y);
        end
        frames(2);
        n_tests++;
        if (form_x !== 12'd175 || form_y !== 12'd60) begin
            n_fail++;
            $display("FAIL march_left: got (%0d,%0d) expected (175,60)", form_x, form_y);
        end
    endtask

    task automatic test_hit_score();
        int cyc;
        logic [1:0] sc;
        do_reset();
        exp_alive = '1;
        hit(150, 135);
        wait_idle(cyc, sc);
        exp_alive[21] = 1'b0;
        n_tests++;
        if (cyc !== 6) begin
            n_fail++;
            $display("FAIL hit_busy_len: got %0d cycles expected 6", cyc);
        end
        n_tests++;
        if (plus_score !== 2'd2) begin
            n_fail++;
            $display("FAIL hit_score: got %0d expected 2", plus_score);
        end
        n_tests++;
        if (alive !== exp_alive) begin
            n_fail++;
            $display("FAIL hit_alive: got %h expected %h", alive, exp_alive);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (plus_score !== 2'd0) begin
            n_fail++;
            $display("FAIL hit_pulse_len: got %0d expected 0", plus_score);
        end
        n_tests++;
        if (expl_valid !== 4'b0001 || expl_x[11:0] !== 12'd146 || expl_y[11:0] !== 12'd129) begin
            n_fail++;
            $display("FAIL hit_expl: got v=%b (%0d,%0d) expected 0001 (146,129)", expl_valid, expl_x[11:0], expl_y[11:0]);
        end
    endtask

    task automatic test_dead_and_ignored();
        int cyc;
        logic [1:0] sc;
        hit(150, 135);
        wait_idle(cyc, sc);
        n_tests++;
        if (sc !== 2'd0 || alive !== exp_alive) begin
            n_fail++;
            $display("FAIL dead_cell: score=%0d alive=%h expected 0 %h", sc, alive, exp_alive);
        end
        hit(95, 45);
        wait_idle(cyc, sc);
        n_tests++;
        if (cyc !== 1 || sc !== 2'd0 || alive !== exp_alive) begin
            n_fail++;
            $display("FAIL negative_dx: cyc=%0d score=%0d expected 1 0", cyc, sc);
        end
        hit(565, 50);
        wait_idle(cyc, sc);
        n_tests++;
        if (sc !== 2'd0 || alive !== exp_alive || expl_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL col_abort: score=%0d expl=%b expected 0 0001", sc, expl_valid);
        end
        hit(105, 50);
        hit(197, 50);
        wait_idle(cyc, sc);
        exp_alive[0] = 1'b0;
        n_tests++;
        if (cyc !== 2 || sc !== 2'd3) begin
            n_fail++;
            $display("FAIL row0_score: cyc=%0d score=%0d expected 2 3", cyc, sc);
        end
        n_tests++;
        if (alive !== exp_alive) begin
            n_fail++;
            $display("FAIL busy_ignore: alive=%h expected %h", alive, exp_alive);
        end
        n_tests++;
        if (expl_valid !== 4'b0011 || expl_x[23:12] !== 12'd100 || expl_y[23:12] !== 12'd45) begin
            n_fail++;
            $display("FAIL expl_slot1: v=%b (%0d,%0d) expected 0011 (100,45)", expl_valid, expl_x[23:12], expl_y[23:12]);
        end
    endtask

    task automatic test_col9();
        int cyc;
        logic [1:0] sc;
        do_reset();
        exp_alive = '1;
        for (int r = 0; r < 5; r++) begin
            hit(519, 50 + r * 42);
            wait_idle(cyc, sc);
            exp_alive[r*10+9] = 1'b0;
        end
        n_tests++;
        if (alive !== exp_alive) begin
            n_fail++;
            $display("FAIL col9_alive: got %h expected %h", alive, exp_alive);
        end
        frames(18);
        n_tests++;
        if (form_x !== 12'd235) begin
            n_fail++;
            $display("FAIL col9_right: form_x=%0d expected 235", form_x);
        end
        frames(4);
        n_tests++;
        if (form_x !== 12'd235 || form_y !== 12'd60) begin
            n_fail++;
            $display("FAIL col9_descend: got (%0d,%0d) expected (235,60)", form_x, form_y);
        end
    endtask

    task automatic test_explosions();
        int cyc;
        logic [1:0] sc;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            hit(105 + 46 * k, 50);
            wait_idle(cyc, sc);
        end
        n_tests++;
        if (expl_valid !== 4'b1111 || expl_x[47:36] !== 12'd238) begin
            n_fail++;
            $display("FAIL expl_fill: v=%b slot3_x=%0d expected 1111 238", expl_valid, expl_x[47:36]);
        end
        hit(289, 50);
        wait_idle(cyc, sc);
        n_tests++;
        if (expl_x[11:0] !== 12'd284 || expl_x[23:12] !== 12'd146) begin
            n_fail++;
            $display("FAIL expl_overwrite: slot0_x=%0d slot1_x=%0d expected 284 146", expl_x[11:0], expl_x[23:12]);
        end
        frames(10);
        freeze = 1'b1;
        frames(5);
        freeze = 1'b0;
        frames(9);
        n_tests++;
        if (expl_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL expl_freeze_stretch: v=%b expected 1111", expl_valid);
        end
        frames(1);
        n_tests++;
        if (expl_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL expl_expire: v=%b expected 0000", expl_valid);
        end
    endtask

    task automatic test_fire();
        int rel;
        int cyc;
        logic stable;
        logic [11:0] fx, fy;
        do_reset();
        frames(8);
        cyc = 0;
        while (!fire_req && cyc < 10) begin
            @(posedge clk);
            #1 cyc++;
        end
        rel = int'(fire_x) - 183;
        n_tests++;
        if (fire_req !== 1'b1 || rel < 0 || rel > 414 || (rel % 46) != 0) begin
            n_fail++;
            $display("FAIL fire_raise: req=%b fire_x=%0d expected 1 and 183+46*c", fire_req, fire_x);
        end
        n_tests++;
        if (fire_y !== 12'd255) begin
            n_fail++;
            $display("FAIL fire_y: got %0d expected 255", fire_y);
        end
        fx = fire_x;
        fy = fire_y;
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (fire_req !== 1'b1 || fire_x !== fx || fire_y !== fy) stable = 1'b0;
        end
        n_tests++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL fire_hold: stable=%b expected 1", stable);
        end
        fire_ack = 1'b1;
        @(posedge clk);
        #1 fire_ack = 1'b0;
        n_tests++;
        if (fire_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fire_drop: req=%b expected 0", fire_req);
        end
    endtask

    task automatic test_clear_all();
        int cyc;
        logic [1:0] sc;
        do_reset();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 10; c++) begin
                hit(105 + 46 * c, 50 + 42 * r);
                wait_idle(cyc, sc);
            end
        @(posedge clk);
        #1;
        n_tests++;
        if (alive !== 50'd0 || finished !== 3'd1) begin
            n_fail++;
            $display("FAIL clear_all: alive=%h fin=%0d expected 0 1", alive, finished);
        end
        frames(4);
        n_tests++;
        if (form_x !== 12'd100 || finished !== 3'd1) begin
            n_fail++;
            $display("FAIL done_hold: form_x=%0d fin=%0d expected 100 1", form_x, finished);
        end
    endtask

    initial begin
        test_reset();
        test_march();
        test_hit_score();
        test_dead_and_ignored();
        test_col9();
        test_explosions();
        test_fire();
        test_clear_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
